// File: rtl/lsu_handshake.sv
// lsu_handshake: sequential load/store unit between execute and data memory.
// Ports: clk/reset_n, core req_*/resp_* (valid/ready), memory mem_* (req/gnt/rvalid).
// Macro LSU_MISALIGNED_EN: split word-crossing accesses into two bus beats.
module lsu_handshake #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

`ifdef LSU_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           hi_q, hi_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word;
    logic [7:0]            be_base;
    logic [7:0]            be_full;
    logic [63:0]           wd_full;
    logic [31:0]           rd_sh;
    logic [31:0]           ld_data;
    logic                  crosses;
    logic                  expire;
    logic                  req_mis;
    logic                  unused_addr;

    assign unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

    assign off  = addr_q[1:0];
    assign word = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        unique case (size_q)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            default: be_base = 8'h0f;
        endcase
    end

    // Lanes above bit 3 belong to the second beat
    assign be_full = be_base << off;
    assign crosses = |be_full[7:4];
    assign wd_full = {32'h0, wdata_q} << {off, 3'b000};
    assign rd_sh   = 32'({hi_q, lo_q} >> {off, 3'b000});
    assign expire  = (cnt_q == CW'(MAX_WAIT - 1));

    always_comb begin
        unique case (size_q)
            2'd0:    ld_data = {{24{sgn_q & rd_sh[7]}}, rd_sh[7:0]};
            2'd1:    ld_data = {{16{sgn_q & rd_sh[15]}}, rd_sh[15:0]};
            default: ld_data = rd_sh;
        endcase
    end

    assign req_mis = (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr[ADDR_WIDTH+1:0];
                    wdata_d = req_wdata;
                    lo_d    = '0;
                    hi_d    = '0;
                    err_d   = 1'b0;
                    if (req_size == 2'd3 || (req_mis && !SPLIT_EN)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ1;
                    end
                end
            end
            S_REQ1: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                // rvalid takes priority over a same-cycle expiry
                if (mem_rvalid) begin
                    lo_d    = mem_rdata;
                    state_d = (crosses && SPLIT_EN) ? S_REQ2 : S_RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ2: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = S_RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = reset_n && (state_q == S_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        unique case (state_q)
            S_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be_full[3:0];
                mem_addr  = word;
                mem_wdata = wd_full[31:0];
            end
            S_REQ2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be_full[7:4];
                mem_addr  = word + 1'b1;
                mem_wdata = wd_full[63:32];
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : ld_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
